// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register pending scoreboard and two prioritised write ports.
// Optional macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero and keeps it never pending.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int N_READ     = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [N_READ*DATA_WIDTH-1:0] read_data,
    output logic [N_READ-1:0]            read_valid,
    input  logic                         wr0_en,
    input  logic [ADDR_WIDTH-1:0]        wr0_addr,
    input  logic [DATA_WIDTH-1:0]        wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_WIDTH-1:0]        wr1_addr,
    input  logic [DATA_WIDTH-1:0]        wr1_data,
    input  logic                         pend_set,
    input  logic [ADDR_WIDTH-1:0]        pend_addr,
    output logic [2**ADDR_WIDTH-1:0]     pending,
    output logic                         wr_collision
);

    localparam int NREG = 2**ADDR_WIDTH;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [NREG-1:0][DATA_WIDTH-1:0] data_all;
    logic                            collision_reg;

    genvar gi;

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (ZERO_REG && gi == 0) begin : g_zero
                assign data_all[gi] = '0;
                assign pending[gi]  = 1'b0;
            end else begin : g_live
                logic [DATA_WIDTH-1:0] data_reg;
                logic                  pend_reg;
                logic                  hit0;
                logic                  hit1;
                logic                  set_hit;

                assign hit0    = wr0_en   && (wr0_addr  == ADDR_WIDTH'(gi));
                assign hit1    = wr1_en   && (wr1_addr  == ADDR_WIDTH'(gi));
                assign set_hit = pend_set && (pend_addr == ADDR_WIDTH'(gi));

                // A new issue in the same cycle as a retiring write keeps the register pending.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        data_reg <= '0;
                        pend_reg <= 1'b0;
                    end else begin
                        if (hit0)
                            data_reg <= wr0_data;
                        else if (hit1)
                            data_reg <= wr1_data;

                        if (set_hit)
                            pend_reg <= 1'b1;
                        else if (hit0 || hit1)
                            pend_reg <= 1'b0;
                    end
                end

                assign data_all[gi] = data_reg;
                assign pending[gi]  = pend_reg;
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < N_READ; gi++) begin : g_read
            logic [ADDR_WIDTH-1:0] addr;

            assign addr                                 = read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_all[addr];
            assign read_valid[gi]                       = ~pending[addr];
        end
    endgenerate

    // Collision is flagged even on a hardwired register 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            collision_reg <= 1'b0;
        else
            collision_reg <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
    end

    assign wr_collision = collision_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios followed by randomized traffic,
// all checked against an array-based model of the register file.
module tb_reg_file_sb;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 2;
    localparam int NREG = 2**AW;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR*AW-1:0]  read_addr;
    logic [NR*DW-1:0]  read_data;
    logic [NR-1:0]     read_valid;
    logic              wr0_en;
    logic [AW-1:0]     wr0_addr;
    logic [DW-1:0]     wr0_data;
    logic              wr1_en;
    logic [AW-1:0]     wr1_addr;
    logic [DW-1:0]     wr1_data;
    logic              pend_set;
    logic [AW-1:0]     pend_addr;
    logic [NREG-1:0]   pending;
    logic              wr_collision;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    logic [DW-1:0]   m_data [NREG];
    logic [NREG-1:0] m_pend;
    logic            m_coll;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .wr0_en       (wr0_en),
        .wr0_addr     (wr0_addr),
        .wr0_data     (wr0_data),
        .wr1_en       (wr1_en),
        .wr1_addr     (wr1_addr),
        .wr1_data     (wr1_data),
        .pend_set     (pend_set),
        .pend_addr    (pend_addr),
        .pending      (pending),
        .wr_collision (wr_collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_data[i] = '0;
        m_pend = '0;
        m_coll = 1'b0;
    endtask

    // Register file semantics: wr0 overrides wr1, a pending issue overrides a retirement.
    task automatic model_edge();
        logic [DW-1:0]   nd [NREG];
        logic [NREG-1:0] np;
        np = m_pend;
        for (int i = 0; i < NREG; i++) nd[i] = m_data[i];
        for (int i = 0; i < NREG; i++) begin
            if (ZR && i == 0) continue;
            if (wr1_en && int'(wr1_addr) == i) begin nd[i] = wr1_data; np[i] = 1'b0; end
            if (wr0_en && int'(wr0_addr) == i) begin nd[i] = wr0_data; np[i] = 1'b0; end
            if (pend_set && int'(pend_addr) == i) np[i] = 1'b1;
        end
        for (int i = 0; i < NREG; i++) m_data[i] = nd[i];
        m_pend = np;
        m_coll = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    endtask

    task automatic check_outputs(input string phase);
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = read_addr[k*AW +: AW];
            check($sformatf("%s_rd%0d_r%0d", phase, k, a), {32'd0, read_data[k*DW +: DW]}, {32'd0, m_data[a]});
            check($sformatf("%s_valid%0d_r%0d", phase, k, a), {63'd0, read_valid[k]}, {63'd0, ~m_pend[a]});
        end
        check({phase, "_pending"}, {48'd0, pending}, {48'd0, m_pend});
        check({phase, "_coll"}, {63'd0, wr_collision}, {63'd0, m_coll});
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        pend_set = 1'b0; pend_addr = '0;
    endtask

    task automatic set_reads(input int a0, input int a1);
        read_addr[0 +: AW]  = AW'(a0);
        read_addr[AW +: AW] = AW'(a1);
    endtask

    // Called with clk low and inputs driven; returns at the next falling edge.
    task automatic cycle();
        #1 check_outputs("pre");
        @(posedge clk);
        model_edge();
        #1 check_outputs("post");
        txn++;
        $display("txn %0d: w0=%0b@%0d:%h w1=%0b@%0d:%h ps=%0b@%0d pend=%h coll=%0b",
                 txn, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
                 pend_set, pend_addr, pending, wr_collision);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic async_reset_pulse();
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(posedge clk);
        #1 check_outputs("arst_hold");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        set_reads(0, 1);
        model_reset();
        @(negedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Mid-cycle async reset clears a freshly written register and the scoreboard.
        wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'hDEADBEEF;
        pend_set = 1'b1; pend_addr = 4'd4;
        set_reads(3, 4);
        cycle();
        check("r3_before_reset", {32'd0, read_data[DW-1:0]}, 64'hDEADBEEF);
        #2 rstn = 1'b0;
        #1;
        check("r3_async_cleared", {32'd0, read_data[DW-1:0]}, 64'h0);
        check("pending_async_cleared", {48'd0, pending}, 64'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Basic write and two read ports.
        wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'h12345678;
        set_reads(5, 6);
        #1 check("r5_old_before_edge", {32'd0, read_data[DW-1:0]}, 64'h0);
        cycle();
        check("r5_port0", {32'd0, read_data[DW-1:0]}, 64'h12345678);
        check("r6_port1", {32'd0, read_data[2*DW-1:DW]}, 64'h0);

        // Same-address collision: wr0 wins, one-cycle pulse.
        wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 32'hAAAA0000;
        wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h0000BBBB;
        set_reads(7, 7);
        cycle();
        check("r7_collision_data", {32'd0, read_data[DW-1:0]}, 64'hAAAA0000);
        check("coll_pulse_high", {63'd0, wr_collision}, 64'd1);
        cycle();
        check("coll_pulse_low", {63'd0, wr_collision}, 64'd0);

        // Scoreboard set, then retirement by wr1 three cycles later.
        pend_set = 1'b1; pend_addr = 4'd9;
        set_reads(9, 5);
        cycle();
        check("r9_not_valid", {63'd0, read_valid[0]}, 64'd0);
        cycle();
        cycle();
        wr1_en = 1'b1; wr1_addr = 4'd9; wr1_data = 32'h55;
        cycle();
        check("r9_valid_after_wr", {63'd0, read_valid[0]}, 64'd1);
        check("r9_data", {32'd0, read_data[DW-1:0]}, 64'h55);

        // Set beats clear on the same register.
        pend_set = 1'b1; pend_addr = 4'd2;
        wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 32'h77;
        set_reads(2, 2);
        cycle();
        check("r2_data", {32'd0, read_data[DW-1:0]}, 64'h77);
        check("r2_still_pending", {63'd0, pending[2]}, 64'd1);

        // Register 0 behaviour depends on the zero-register build option.
        wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 32'hFFFFFFFF;
        pend_set = 1'b1; pend_addr = 4'd0;
        set_reads(0, 0);
        cycle();
        check("r0_data", {32'd0, read_data[DW-1:0]}, ZR ? 64'h0 : 64'hFFFFFFFF);
        check("r0_pending", {63'd0, pending[0]}, ZR ? 64'd0 : 64'd1);
        check("r0_valid", {63'd0, read_valid[1]}, ZR ? 64'd1 : 64'd0);

        // Randomized traffic with frequent collisions and occasional async resets.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset_pulse();
                continue;
            end
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_addr = AW'($urandom_range(0, NREG-1));
            wr0_data = DW'($urandom);
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, NREG-1));
            wr1_data = DW'($urandom);
            pend_set  = ($urandom_range(0, 2) == 0);
            pend_addr = ($urandom_range(0, 4) == 0) ? wr1_addr : AW'($urandom_range(0, NREG-1));
            set_reads($urandom_range(0, NREG-1), $urandom_range(0, NREG-1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
